mult_div_unit: RTL and testbench

//   Multi-cycle multiply/divide unit with architectural HI/LO registers, in the EX stage.

---
 rtl/mult_div_unit_pkg.sv | 20 ++
 rtl/mdu_arith.sv | 63 ++++++
 rtl/mult_div_unit.sv | 101 ++++++++++
 tb/tb_mult_div_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared datapath definitions for the multiply/divide unit.
// MD_* operation encodings (3-bit), used by the decoder and by the EX-stage MD unit.
package mult_div_unit_pkg;

    localparam int unsigned MdOpW = 3;

    typedef enum logic [MdOpW-1:0] {
        MdMult  = 3'd0,
        MdMultu = 3'd1,
        MdDiv   = 3'd2,
        MdDivu  = 3'd3,
        MdMthi  = 3'd4,
        MdMtlo  = 3'd5
    } md_op_e;

    function automatic logic is_div_op(md_op_e op);
        return (op == MdDiv) || (op == MdDivu);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational arithmetic core of the multiply/divide unit.
// Ports:
//   md_op_i        operation code (md_op_e)
//   a_i, b_i       rs / rt operands
//   div_by_zero_o  high for DIV/DIVU with b_i == 0
//   hi_o, lo_o     product high/low half, or remainder/quotient
module mdu_arith
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [MdOpW-1:0] md_op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    md_op_e             op;
    logic               signed_op;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic               a_neg, b_neg, b_zero;
    logic [WIDTH-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

    assign op = md_op_e'(md_op_i);

    always_comb begin
        signed_op = (op == MdMult) || (op == MdDiv);

        // Low 2*WIDTH bits of the product of the extended operands are exact for both
        // signed and unsigned multiplication.
        a_ext = signed_op ? {{WIDTH{a_i[WIDTH-1]}}, a_i} : {{WIDTH{1'b0}}, a_i};
        b_ext = signed_op ? {{WIDTH{b_i[WIDTH-1]}}, b_i} : {{WIDTH{1'b0}}, b_i};
        prod  = a_ext * b_ext;

        // Signed division on magnitudes: avoids the most-negative / -1 overflow case,
        // since |most-negative| is representable as an unsigned magnitude.
        a_neg  = signed_op & a_i[WIDTH-1];
        b_neg  = signed_op & b_i[WIDTH-1];
        a_mag  = a_neg ? (WIDTH'(0) - a_i) : a_i;
        b_mag  = b_neg ? (WIDTH'(0) - b_i) : b_i;
        b_zero = (b_i == '0);
        b_safe = b_zero ? WIDTH'(1) : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quot   = (a_neg ^ b_neg) ? (WIDTH'(0) - q_mag) : q_mag;
        rem    = a_neg ? (WIDTH'(0) - r_mag) : r_mag;

        div_by_zero_o = is_div_op(op) & b_zero;
        hi_o          = '0;
        lo_o          = '0;
        case (op)
            MdMult, MdMultu: {hi_o, lo_o} = prod;
            MdDiv, MdDivu: begin
                hi_o = rem;
                lo_o = quot;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multi-cycle multiply/divide unit with architectural HI/LO registers.
// Ports:
//   clk_i, reset_i      clock, synchronous active-high reset
//   start_i, flush_i    op valid / op cancelled (flush suppresses start)
//   md_op_i             MD operation code
//   src_a_i, src_b_i    rs / rt values
//   busy_o              multi-cycle op in flight (registered, counter != 0)
//   hi_o, lo_o          HI / LO registers
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [MdOpW-1:0] md_op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    output logic             busy_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   res_q, res_d;
    logic                 skip_q, skip_d;  // divide by zero: leave HI/LO untouched
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;

    logic                 ar_dbz;
    logic [WIDTH-1:0]     ar_hi, ar_lo;

    mdu_arith #(
        .WIDTH(WIDTH)
    ) u_arith (
        .md_op_i      (md_op_i),
        .a_i          (src_a_i),
        .b_i          (src_b_i),
        .div_by_zero_o(ar_dbz),
        .hi_o         (ar_hi),
        .lo_o         (ar_lo)
    );

    assign busy_o = (cnt_q != '0);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

    always_comb begin
        cnt_d  = cnt_q;
        res_d  = res_q;
        skip_d = skip_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (busy_o) begin
            // Starts while busy are ignored; the result lands as the counter expires.
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1) && !skip_q) begin
                {hi_d, lo_d} = res_q;
            end
        end else if (start_i && !flush_i) begin
            case (md_op_e'(md_op_i))
                MdMthi: hi_d = src_a_i;
                MdMtlo: lo_d = src_a_i;
                MdMult, MdMultu: begin
                    cnt_d  = CntW'(MULT_CYCLES);
                    res_d  = {ar_hi, ar_lo};
                    skip_d = 1'b0;
                end
                MdDiv, MdDivu: begin
                    cnt_d  = CntW'(DIV_CYCLES);
                    res_d  = {ar_hi, ar_lo};
                    skip_d = ar_dbz;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            res_q  <= '0;
            skip_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            res_q  <= res_d;
            skip_q <= skip_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized traffic,
// all compared against a behavioural model of HI/LO and the busy window.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] a = '0, b = '0;
    logic        busy;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    mult_div_unit #(
        .WIDTH      (32),
        .MULT_CYCLES(MC),
        .DIV_CYCLES (DC)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .start_i(start),
        .flush_i(flush),
        .md_op_i(md_op),
        .src_a_i(a),
        .src_b_i(b),
        .busy_o (busy),
        .hi_o   (hi),
        .lo_o   (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Behavioural model: HI/LO, cycles remaining, pending result.
    logic [31:0]     m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
    int              m_rem = 0;
    bit              m_pend = 1'b0;
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up, uq, ur;

    always @(posedge clk) begin
        if (reset) begin
            m_hi = '0; m_lo = '0; m_rem = 0; m_pend = 1'b0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && m_pend) begin
                m_hi = m_phi; m_lo = m_plo;
            end
        end else if (start && !flush) begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
            ua = {32'b0, a};           ub = {32'b0, b};
            case (md_op)
                3'd0: begin sp = sa * sb; m_phi = sp[63:32]; m_plo = sp[31:0]; m_rem = MC; m_pend = 1; end
                3'd1: begin up = ua * ub; m_phi = up[63:32]; m_plo = up[31:0]; m_rem = MC; m_pend = 1; end
                3'd2: begin
                    m_rem = DC; m_pend = (b != 0);
                    if (b != 0) begin sq = sa / sb; sr = sa % sb; m_plo = sq[31:0]; m_phi = sr[31:0]; end
                end
                3'd3: begin
                    m_rem = DC; m_pend = (b != 0);
                    if (b != 0) begin uq = ua / ub; ur = ua % ub; m_plo = uq[31:0]; m_phi = ur[31:0]; end
                end
                3'd4: m_hi = a;
                3'd5: m_lo = a;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_busy", 32'(busy), 32'(m_rem != 0));
            check("mdl_hi", hi, m_hi);
            check("mdl_lo", lo, m_lo);
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         input bit fl = 1'b0);
        md_op = op; a = x; b = y; start = 1'b1; flush = fl;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
    endtask

    // Counts the remaining busy cycles (bounded) and compares with n.
    task automatic wait_busy(input string name, input int n);
        int c = 0;
        while (busy === 1'b1 && c < 200) begin
            c++;
            @(posedge clk); #1;
        end
        check(name, 32'(c), 32'(n));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);

        issue(MdMult, 32'hFFFF_FFFE, 32'd3);
        wait_busy("mult_lat", MC);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        issue(MdMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_busy("multu_lat", MC);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);

        issue(MdDiv, 32'hFFFF_FFF9, 32'd2);
        wait_busy("div_lat", DC);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        issue(MdDivu, 32'hFFFF_FFF9, 32'd2);
        wait_busy("divu_lat", DC);
        check("divu_lo", lo, 32'h7FFF_FFFC);
        check("divu_hi", hi, 32'h0000_0001);

        issue(MdDiv, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_busy("divovf_lat", DC);
        check("divovf_lo", lo, 32'h8000_0000);
        check("divovf_hi", hi, 32'h0);

        issue(MdMthi, 32'h0000_1234, 32'h0);
        check("mthi_hi", hi, 32'h0000_1234);
        check("mthi_busy", 32'(busy), 32'h0);
        issue(MdMtlo, 32'h5555_5555, 32'h0, 1'b1);
        check("mtlo_flush_lo", lo, 32'h8000_0000);
        check("mtlo_flush_busy", 32'(busy), 32'h0);

        issue(MdMthi, 32'hA, 32'h0);
        issue(MdMtlo, 32'hB, 32'h0);
        issue(MdDiv, 32'd5, 32'd0);
        md_op = MdMult; a = 32'd5; b = 32'd5; start = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        start = 1'b0;
        wait_busy("div0_lat_rest", DC - 3);
        check("div0_hi", hi, 32'hA);
        check("div0_lo", lo, 32'hB);

        issue(MdMult, 32'd7, 32'd9);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        reset = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        check("midrst_late_hi", hi, 32'h0);
        check("midrst_late_lo", lo, 32'h0);

        repeat (600) begin
            reset = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 4) == 0);
            md_op = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            @(posedge clk); #1;
        end
        reset = 1'b0; start = 1'b0; flush = 1'b0;
        repeat (DC + 2) begin @(posedge clk); #1; end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
